// File: rtl/robot_motion_monitor.sv
// Always-on supervisor for the robot pose stream: checks every valid sample
// against the map bounds and the legal motion rules, counts moves and turns,
// and latches the first anomaly with a reason code.
module robot_motion_monitor #(
    parameter int ROWS        = 10,
    parameter int COLS        = 20,
    parameter int STUCK_LIMIT = 8,
    parameter int SPIN_LIMIT  = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [5:0]       robot_row,
    input  logic [5:0]       robot_column,
    input  logic [2:0]       robot_orientation,
    input  logic             clear_alarm,
    output logic             alarm,
    output logic [2:0]       alarm_code,
    output logic [CNT_W-1:0] move_count,
    output logic [CNT_W-1:0] turn_count,
    output logic             tracking
);

    localparam int STUCK_W = $clog2(STUCK_LIMIT + 1);
    localparam int SPIN_W  = $clog2(SPIN_LIMIT + 1);

    localparam logic [5:0]         ROW_MAX    = 6'(ROWS);
    localparam logic [5:0]         COL_MAX    = 6'(COLS);
    localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_LIMIT - 1);
    localparam logic [SPIN_W-1:0]  SPIN_LAST  = SPIN_W'(SPIN_LIMIT - 1);

    localparam logic [2:0] CODE_NONE         = 3'd0;
    localparam logic [2:0] CODE_OUT_OF_MAP   = 3'd1;
    localparam logic [2:0] CODE_BAD_ORIENT   = 3'd2;
    localparam logic [2:0] CODE_ILLEGAL_MOVE = 3'd3;
    localparam logic [2:0] CODE_STUCK        = 3'd4;
    localparam logic [2:0] CODE_SPIN         = 3'd5;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        TRACK      = 2'd1,
        ALARM      = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         code_d;
    logic [CNT_W-1:0]   move_d, turn_d;
    logic [5:0]         prev_row_q, prev_row_d;
    logic [5:0]         prev_col_q, prev_col_d;
    logic [2:0]         prev_ori_q, prev_ori_d;
    logic [STUCK_W-1:0] stuck_cnt_q, stuck_cnt_d;
    logic [SPIN_W-1:0]  spin_cnt_q, spin_cnt_d;

    logic signed [6:0]  d_row, d_col;
    logic               out_of_map, bad_orient;
    logic               same_pos, same_ori;
    logic               is_identical, is_turn, is_forward;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic signed [6:0] row_step(input logic [2:0] ori);
        case (ori)
            3'd0:    return -7'sd1;
            3'd1:    return 7'sd1;
            default: return 7'sd0;
        endcase
    endfunction

    function automatic logic signed [6:0] col_step(input logic [2:0] ori);
        case (ori)
            3'd2:    return 7'sd1;
            3'd3:    return -7'sd1;
            default: return 7'sd0;
        endcase
    endfunction

    // 7-bit signed deltas keep row/column 1 minus 1 from aliasing to a legal step
    assign d_row = $signed({1'b0, robot_row})    - $signed({1'b0, prev_row_q});
    assign d_col = $signed({1'b0, robot_column}) - $signed({1'b0, prev_col_q});

    assign out_of_map = (robot_row == 6'd0) || (robot_row > ROW_MAX) ||
                        (robot_column == 6'd0) || (robot_column > COL_MAX);
    assign bad_orient = robot_orientation > 3'd3;

    assign same_pos     = (d_row == 7'sd0) && (d_col == 7'sd0);
    assign same_ori     = robot_orientation == prev_ori_q;
    assign is_identical = same_pos && same_ori;
    assign is_turn      = same_pos && !same_ori;
    assign is_forward   = same_ori && (d_row == row_step(prev_ori_q)) &&
                          (d_col == col_step(prev_ori_q));

    always_comb begin
        state_d     = state_q;
        code_d      = alarm_code;
        move_d      = move_count;
        turn_d      = turn_count;
        prev_row_d  = prev_row_q;
        prev_col_d  = prev_col_q;
        prev_ori_d  = prev_ori_q;
        stuck_cnt_d = stuck_cnt_q;
        spin_cnt_d  = spin_cnt_q;

        case (state_q)
            WAIT_FIRST: begin
                if (sample_valid) begin
                    if (out_of_map) begin
                        code_d  = CODE_OUT_OF_MAP;
                        state_d = ALARM;
                    end else if (bad_orient) begin
                        code_d  = CODE_BAD_ORIENT;
                        state_d = ALARM;
                    end else begin
                        prev_row_d = robot_row;
                        prev_col_d = robot_column;
                        prev_ori_d = robot_orientation;
                        state_d    = TRACK;
                    end
                end
            end

            TRACK: begin
                if (sample_valid) begin
                    // An offending sample leaves counters and previous pose untouched
                    if (out_of_map) begin
                        code_d  = CODE_OUT_OF_MAP;
                        state_d = ALARM;
                    end else if (bad_orient) begin
                        code_d  = CODE_BAD_ORIENT;
                        state_d = ALARM;
                    end else if (!(is_identical || is_turn || is_forward)) begin
                        code_d  = CODE_ILLEGAL_MOVE;
                        state_d = ALARM;
                    end else if (is_identical && (stuck_cnt_q == STUCK_LAST)) begin
                        code_d  = CODE_STUCK;
                        state_d = ALARM;
                    end else if (is_turn && (spin_cnt_q == SPIN_LAST)) begin
                        code_d  = CODE_SPIN;
                        state_d = ALARM;
                    end else begin
                        prev_row_d = robot_row;
                        prev_col_d = robot_column;
                        prev_ori_d = robot_orientation;
                        if (is_identical) begin
                            stuck_cnt_d = stuck_cnt_q + STUCK_W'(1);
                        end else if (is_turn) begin
                            turn_d      = sat_inc(turn_count);
                            spin_cnt_d  = spin_cnt_q + SPIN_W'(1);
                            stuck_cnt_d = '0;
                        end else begin
                            move_d      = sat_inc(move_count);
                            stuck_cnt_d = '0;
                            spin_cnt_d  = '0;
                        end
                    end
                end
            end

            ALARM: begin
                // Clear takes precedence; a coincident sample is simply dropped
                if (clear_alarm) begin
                    code_d      = CODE_NONE;
                    stuck_cnt_d = '0;
                    spin_cnt_d  = '0;
                    state_d     = WAIT_FIRST;
                end
            end

            default: begin
                state_d = WAIT_FIRST;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT_FIRST;
            alarm       <= 1'b0;
            alarm_code  <= CODE_NONE;
            tracking    <= 1'b0;
            move_count  <= '0;
            turn_count  <= '0;
            prev_row_q  <= '0;
            prev_col_q  <= '0;
            prev_ori_q  <= '0;
            stuck_cnt_q <= '0;
            spin_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            alarm       <= (state_d == ALARM);
            alarm_code  <= code_d;
            tracking    <= (state_d == TRACK);
            move_count  <= move_d;
            turn_count  <= turn_d;
            prev_row_q  <= prev_row_d;
            prev_col_q  <= prev_col_d;
            prev_ori_q  <= prev_ori_d;
            stuck_cnt_q <= stuck_cnt_d;
            spin_cnt_q  <= spin_cnt_d;
        end
    end

endmodule

// File: tb/tb_robot_motion_monitor.sv
// Randomized and directed bench for robot_motion_monitor against a pose-rule
// reference model; a narrow-counter instance exposes counter saturation.
module tb_robot_motion_monitor;

    localparam int ROWS        = 10;
    localparam int COLS        = 20;
    localparam int STUCK_LIMIT = 8;
    localparam int SPIN_LIMIT  = 4;
    localparam int SMALL_MAX   = 7;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic [5:0]  robot_row = '0;
    logic [5:0]  robot_column = '0;
    logic [2:0]  robot_orientation = '0;
    logic        clear_alarm = 1'b0;

    logic        alarm, tracking;
    logic [2:0]  alarm_code;
    logic [15:0] move_count, turn_count;

    logic        s_alarm, s_tracking;
    logic [2:0]  s_alarm_code;
    logic [2:0]  s_move_count, s_turn_count;

    robot_motion_monitor dut (
        .clock(clock), .reset(reset), .sample_valid(sample_valid),
        .robot_row(robot_row), .robot_column(robot_column),
        .robot_orientation(robot_orientation), .clear_alarm(clear_alarm),
        .alarm(alarm), .alarm_code(alarm_code), .move_count(move_count),
        .turn_count(turn_count), .tracking(tracking)
    );

    robot_motion_monitor #(.CNT_W(3)) dut_small (
        .clock(clock), .reset(reset), .sample_valid(sample_valid),
        .robot_row(robot_row), .robot_column(robot_column),
        .robot_orientation(robot_orientation), .clear_alarm(clear_alarm),
        .alarm(s_alarm), .alarm_code(s_alarm_code), .move_count(s_move_count),
        .turn_count(s_turn_count), .tracking(s_tracking)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: rule-level view of the robot history
    bit m_alarm, m_have;
    int m_code, m_moves, m_turns, m_stuck, m_spin;
    int pr, pc, po;
    int DR[4] = '{-1, 1, 0, 0};
    int DC[4] = '{0, 0, 1, -1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_alarm = 0; m_have = 0; m_code = 0;
        m_moves = 0; m_turns = 0; m_stuck = 0; m_spin = 0;
        pr = 0; pc = 0; po = 0;
    endtask

    task automatic model_step(input bit v, input int r, input int c, input int o, input bit clr);
        int code, dr, dc;
        bit same;
        if (m_alarm) begin
            if (clr) begin
                m_alarm = 0; m_code = 0; m_have = 0; m_stuck = 0; m_spin = 0;
            end
            return;
        end
        if (!v) return;
        code = 0;
        dr = r - pr;
        dc = c - pc;
        same = (dr == 0) && (dc == 0);
        if (r < 1 || r > ROWS || c < 1 || c > COLS) code = 1;
        else if (o > 3) code = 2;
        else if (m_have) begin
            if (same && o == po) begin
                if (m_stuck + 1 >= STUCK_LIMIT) code = 4;
            end else if (same) begin
                if (m_spin + 1 >= SPIN_LIMIT) code = 5;
            end else if (!(o == po && dr == DR[po] && dc == DC[po])) begin
                code = 3;
            end
        end
        if (code != 0) begin
            m_alarm = 1;
            m_code = code;
            return;
        end
        if (m_have) begin
            if (same && o == po) m_stuck++;
            else if (same) begin m_turns++; m_spin++; m_stuck = 0; end
            else begin m_moves++; m_stuck = 0; m_spin = 0; end
        end
        m_have = 1;
        pr = r; pc = c; po = o;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".alarm"}, alarm, m_alarm);
        chk({tag, ".code"}, alarm_code, m_code);
        chk({tag, ".track"}, tracking, m_have && !m_alarm);
        chk({tag, ".moves"}, move_count, sat(m_moves, 65535));
        chk({tag, ".turns"}, turn_count, sat(m_turns, 65535));
        chk({tag, ".s_alarm"}, s_alarm, m_alarm);
        chk({tag, ".s_moves"}, s_move_count, sat(m_moves, SMALL_MAX));
        chk({tag, ".s_turns"}, s_turn_count, sat(m_turns, SMALL_MAX));
    endtask

    task automatic step(input string tag, input bit v, input int r, input int c, input int o,
                        input bit clr);
        @(negedge clock);
        sample_valid      = v;
        robot_row         = 6'(r);
        robot_column      = 6'(c);
        robot_orientation = 3'(o);
        clear_alarm       = clr;
        @(posedge clock);
        model_step(v, r, c, o, clr);
        #1 compare_all(tag);
    endtask

    // One world update: a valid sample followed by an idle cycle with a scrambled pose
    task automatic pose(input string tag, input int r, input int c, input int o);
        step(tag, 1'b1, r, c, o, 1'b0);
        step({tag, ".idle"}, 1'b0, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
             int'($urandom_range(0, 7)), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        sample_valid = 1'b0;
        clear_alarm = 1'b0;
        model_reset();
        #1 compare_all("rst");
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int r, c, o, k;
        model_reset();
        do_reset();

        // Straight moves south
        pose("t1", 1, 1, 1);
        pose("t1", 2, 1, 1);
        pose("t1", 3, 1, 1);
        chk("t1.move2", move_count, 2);

        // Jump of two cells, then an ignored sample
        do_reset();
        pose("t2", 5, 5, 2);
        pose("t2", 5, 7, 2);
        chk("t2.code3", alarm_code, 3);
        pose("t2", 5, 8, 2);

        // Out of map first pose, clear, then a legal corner pose
        do_reset();
        pose("t3", 1, 21, 0);
        chk("t3.code1", alarm_code, 1);
        step("t3.clr", 1'b0, 0, 0, 0, 1'b1);
        pose("t3", 1, 20, 3);
        chk("t3.track", tracking, 1);
        pose("t3", 0, 20, 3);

        // Stuck on the 8th identical sample after the first
        do_reset();
        for (int i = 0; i < 9; i++) pose("t4", 4, 4, 0);
        chk("t4.code4", alarm_code, 4);
        do_reset();
        for (int i = 0; i < 7; i++) pose("t4b", 4, 4, 0);
        pose("t4b", 4, 4, 2);
        chk("t4b.noalarm", alarm, 0);
        chk("t4b.turn1", turn_count, 1);

        // Spin on the 4th consecutive turn, then a bad orientation on a fresh track
        do_reset();
        pose("t5", 4, 4, 0);
        pose("t5", 4, 4, 2);
        pose("t5", 4, 4, 1);
        pose("t5", 4, 4, 3);
        pose("t5", 4, 4, 0);
        chk("t5.code5", alarm_code, 5);
        chk("t5.turn3", turn_count, 3);
        step("t5.clr", 1'b0, 0, 0, 0, 1'b1);
        pose("t5", 3, 3, 6);
        chk("t5.code2", alarm_code, 2);

        // Asynchronous reset mid-track, then clear racing a sample
        do_reset();
        for (int i = 0; i < 6; i++) pose("t6", 2 + i, 2, 1);
        chk("t6.move5", move_count, 5);
        @(posedge clock);
        #3 reset = 1'b0;
        model_reset();
        #1 compare_all("t6.async");
        @(negedge clock);
        reset = 1'b1;
        pose("t6", 1, 1, 0);
        pose("t6", 0, 1, 0);
        step("t6.clrvld", 1'b1, 1, 1, 0, 1'b1);
        chk("t6.dropped", tracking, 0);

        // Saturation of the narrow counters: nine moves south
        do_reset();
        for (int i = 1; i <= 10; i++) pose("sat", i, 3, 1);
        chk("sat.small", s_move_count, SMALL_MAX);

        // Randomized operation
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            k = int'($urandom_range(0, 99));
            if (k == 0) begin
                do_reset();
            end else if (m_alarm) begin
                if (k < 35) step("rnd.clr", $urandom_range(0, 1) == 1, int'($urandom_range(0, 11)),
                                 int'($urandom_range(0, 21)), int'($urandom_range(0, 3)), 1'b1);
                else pose("rnd.ign", int'($urandom_range(0, 11)), int'($urandom_range(0, 21)),
                          int'($urandom_range(0, 3)));
            end else if (!m_have) begin
                r = int'($urandom_range(0, 11));
                c = int'($urandom_range(0, 21));
                o = (k < 90) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7));
                pose("rnd.first", r, c, o);
            end else if (k < 40) begin
                pose("rnd.fwd", pr + DR[po], pc + DC[po], po);
            end else if (k < 60) begin
                pose("rnd.same", pr, pc, po);
            end else if (k < 80) begin
                pose("rnd.turn", pr, pc, (po + 1 + int'($urandom_range(0, 2))) % 4);
            end else if (k < 90) begin
                pose("rnd.jump", pr + int'($urandom_range(0, 4)) - 2,
                     pc + int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 3)));
            end else if (k < 95) begin
                pose("rnd.bad", pr, pc, int'($urandom_range(4, 7)));
            end else begin
                step("rnd.idle", 1'b0, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                     int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
